// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin write-back arbiter and busy scoreboard for the register file write port
// Optional WB_BYPASS_EN: forward BusW to decode while the matching write is in flight.
module regfile_wb_arbiter #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rw,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_rw,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rw,
  input  logic [ADDR_W-1:0] RA,
  input  logic [ADDR_W-1:0] RB,
  output logic              hazard_a,
  output logic              hazard_b,
  output logic              fwd_a,
  output logic              fwd_b,
  output logic [ADDR_W-1:0] RW,
  output logic [DATA_W-1:0] BusW,
  output logic              RegWr
);

  localparam int NumRegs = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(ZERO_REG);

  logic               rrPtr;
  logic [NumRegs-1:0] busy;
  logic [NumRegs-1:0] busyNext;
  logic               grant;
  logic [ADDR_W-1:0]  winRw;
  logic [DATA_W-1:0]  winData;

  // rrPtr==0 prefers the ALU, rrPtr==1 prefers the load path
  assign alu_ready = alu_valid & (~mem_valid | ~rrPtr);
  assign mem_ready = mem_valid & (~alu_valid | rrPtr);
  assign grant     = alu_ready | mem_ready;
  assign winRw     = alu_ready ? alu_rw : mem_rw;
  assign winData   = alu_ready ? alu_data : mem_data;

  // Clear is applied before set so a newly issued producer keeps the bit busy
  always_comb begin
    busyNext = busy;
    if (RegWr) begin
      busyNext[RW] = 1'b0;
    end
    if (issue_valid && (issue_rw != ZeroAddr)) begin
      busyNext[issue_rw] = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rrPtr <= 1'b0;
      busy  <= '0;
      RW    <= '0;
      BusW  <= '0;
      RegWr <= 1'b0;
    end else begin
      busy  <= busyNext;
      RegWr <= grant && (winRw != ZeroAddr);
      if (grant) begin
        rrPtr <= alu_ready;
        RW    <= winRw;
        BusW  <= winData;
      end
    end
  end

`ifdef WB_BYPASS_EN
  assign fwd_a = RegWr && (RW == RA) && (RA != ZeroAddr);
  assign fwd_b = RegWr && (RW == RB) && (RB != ZeroAddr);
`else
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif

  assign hazard_a = busy[RA] && (RA != ZeroAddr) && !fwd_a;
  assign hazard_b = busy[RB] && (RB != ZeroAddr) && !fwd_b;

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Write-back controller for the 32x64 register file's single write port.
- Arbitrates round-robin between two write-back requesters, the ALU and memory-load paths, using valid/ready handshakes.
- Drives registered RW/BusW/RegWr into the register file, which writes on negedge Clk.
- Maintains a busy-register scoreboard so decode can detect read-after-write hazards on RA/RB.

Parameters:
- DATA_W, 64, write data width.
- ADDR_W, 5, register address width (2**ADDR_W registers).
- ZERO_REG, 31, hardwired register; writes to it are discarded.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Rst_n  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU write-back request.
- alu_rw  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- alu_ready  out  1  ALU request accepted this cycle (combinational).
- mem_valid  in  1  load write-back request.
- mem_rw  in  ADDR_W  load destination register.
- mem_data  in  DATA_W  load data.
- mem_ready  out  1  load request accepted this cycle (combinational).
- issue_valid  in  1  decode issues an instruction with a destination.
- issue_rw  in  ADDR_W  destination to mark busy.
- RA, RB  in  ADDR_W each  source registers being read by decode.
- hazard_a, hazard_b  out  1 each  RA/RB busy (combinational).
- fwd_a, fwd_b  out  1 each  BusW may be forwarded for RA/RB (see Optional Feature).
- RW  out  ADDR_W  register file write address (registered).
- BusW  out  DATA_W  register file write data (registered).
- RegWr  out  1  register file write enable (registered).

Behaviour:
- Reset (async, Rst_n=0):
  - RegWr=0, RW=0, BusW=0.
  - All busy bits=0.
  - rr_ptr=0 (ALU preferred).
  - alu_ready/mem_ready follow from valid inputs once reset releases.
- Arbitration:
  - At most one grant per cycle.
  - alu_ready = alu_valid & (!mem_valid | rr_ptr==0).
  - mem_ready = mem_valid & (!alu_valid | rr_ptr==1).
  - On a grant with both requesters valid, rr_ptr toggles to the other requester.
  - On a single-requester grant, rr_ptr is set to the non-granted requester.
  - A requester holds valid/rw/data stable until ready; ready is never asserted without valid.
- Write timing:
  - Transfer accepted at posedge N.
  - Cycle N..N+1: RegWr=1, RW/BusW = winner's rw/data.
  - Register file commits at the negedge inside that cycle.
  - With no grant at posedge N, RegWr=0 for the following cycle; RW/BusW hold their last values.
  - Back-to-back grants give continuous RegWr=1, one write per cycle.
- Zero register:
  - A granted request with rw==ZERO_REG completes its handshake normally.
  - RegWr stays 0 for that slot; no scoreboard change.
- Scoreboard:
  - issue_valid at posedge sets busy[issue_rw]; ignored when issue_rw==ZERO_REG.
  - The busy bit for RW clears at the posedge ending a RegWr=1 cycle.
  - Same-cycle set and clear of the same register: set wins (newer producer pending).
  - hazard_a = busy[RA], hazard_b = busy[RB]; always 0 for ZERO_REG.
- No ordering guarantee between requesters for the same destination; issue logic serialises producers.
- Reset mid-write: RegWr drops immediately (async), and the in-flight write may be lost.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - While RegWr=1 and RW==RA (RA!=ZERO_REG), fwd_a=1 and hazard_a=0; decode takes BusW instead of BusA.
  - Same for RB with fwd_b/hazard_b.
- Undefined:
  - fwd_a=fwd_b=0 constantly.
  - hazard_a/hazard_b stay high until the busy bit clears at the end of the write cycle.

Test Plan:
- Reset, then ALU-only: issue_rw=5; alu_valid, rw=5, data=0xDEAD_BEEF -> alu_ready=1 same cycle; next cycle RegWr=1, RW=5, BusW=0xDEADBEEF; hazard_a (RA=5) high until that cycle ends, then 0.
- Both valid for 4 cycles, ALU rw=1..4, mem rw=10..13 -> grants alternate ALU, mem, ALU, mem starting with ALU; RegWr continuous; each requester sees exactly one ready per two cycles.
- alu_rw=31, data=0x1 -> alu_ready=1; RegWr stays 0; issue_rw=31 never raises hazard for RA=31.
- issue_rw=7 in the same cycle as the busy-clear of an older write to 7 -> busy[7] remains 1; hazard_b (RB=7) stays high.
- Rst_n low asynchronously during a RegWr=1 cycle with busy[3]=1 -> RegWr=0 immediately; busy cleared; after release, the first grant goes to the ALU.
- WB_BYPASS_EN defined, RegWr=1, RW=9, RA=9 -> fwd_a=1, hazard_a=0; undefined -> fwd_a=0, hazard_a=1.
